// File: rtl/rs_pkg.sv
// rs_pkg: shared field constants, generator table and FSM state type for rs_encoder.
// The generator coefficients are expanded from the field definition at elaboration time.
package rs_pkg;

    localparam int         NPAR      = 16;
    localparam int         MAX_K     = 239;
    localparam logic [8:0] PRIM_POLY = 9'h11D;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MSG    = 2'd1,
        PARITY = 2'd2
    } rs_state_e;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? PRIM_POLY[7:0] : 8'h00);
        end
        return acc;
    endfunction

    // Expands prod(x + alpha^i) for i=0..NPAR-1; the monic x^NPAR term is implied.
    function automatic logic [NPAR-1:0][7:0] calcGenPoly();
        logic [NPAR:0][7:0] g;
        logic [7:0]         root;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            for (int j = NPAR; j > 0; j--) begin
                g[j] = g[j-1] ^ gfMul(g[j], root);
            end
            g[0] = gfMul(g[0], root);
            root = gfMul(root, 8'h02);
        end
        return g[NPAR-1:0];
    endfunction

    localparam logic [NPAR-1:0][7:0] GEN_COEF = calcGenPoly();

endpackage

// File: rtl/gf256_mul.sv
// gf256_mul: combinational multiplier in GF(256) with primitive polynomial 0x11D.
// Tied to a constant operand, it reduces to a fixed XOR network.
module gf256_mul
    import rs_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);

    assign p_o = gfMul(a_i, b_i);

endmodule

// File: rtl/rs_encoder.sv
// rs_encoder: systematic Reed-Solomon encoder, K message + 16 parity symbols per codeword.
// Defining RS_ENC_VARLEN_EN adds a msg_len input sampled per frame in place of K.
module rs_encoder #(
    parameter int K    = 239,
    parameter int NPAR = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
`ifdef RS_ENC_VARLEN_EN
    input  logic [7:0] msg_len,
`endif
    output logic       dout_last
);

    import rs_pkg::*;

    localparam logic [7:0] PAR_LEN = 8'(NPAR);

    rs_state_e             state_q, state_d;
    logic [7:0]            msgCnt_q, msgCnt_d;
    logic [7:0]            parCnt_q, parCnt_d;
    logic [NPAR-1:0][7:0]  par_q, par_d;
    logic [7:0]            dout_q, dout_d;
    logic                  doutValid_q, doutValid_d;
    logic                  doutLast_q, doutLast_d;

    logic                  slotFree;
    logic                  accept;
    logic [7:0]            feedback;
    logic [7:0]            msgCntNext;
    logic [7:0]            msgLenCur;
    logic [NPAR-1:0][7:0]  tapProd;

`ifdef RS_ENC_VARLEN_EN
    logic [7:0] frameLen_q;
    logic [7:0] lenIn;

    assign lenIn     = (msg_len == 8'd0 || msg_len > 8'(MAX_K)) ? 8'(MAX_K) : msg_len;
    assign msgLenCur = (state_q == IDLE) ? lenIn : frameLen_q;

    // Length is captured on the first accept so it stays fixed for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frameLen_q <= 8'(MAX_K);
        end else if (accept && state_q == IDLE) begin
            frameLen_q <= lenIn;
        end
    end
`else
    localparam logic [7:0] FIXED_LEN = 8'(K);

    assign msgLenCur = FIXED_LEN;
`endif

    assign slotFree   = !doutValid_q || dout_ready;
    assign din_ready  = (state_q != PARITY) && slotFree;
    assign accept     = din_valid && din_ready;
    assign feedback   = din ^ par_q[NPAR-1];
    assign msgCntNext = msgCnt_q + 8'd1;

    for (genvar i = 0; i < NPAR; i++) begin : g_tap
        gf256_mul u_mul (
            .a_i (feedback),
            .b_i (GEN_COEF[i]),
            .p_o (tapProd[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        msgCnt_d    = msgCnt_q;
        parCnt_d    = parCnt_q;
        par_d       = par_q;
        dout_d      = dout_q;
        doutValid_d = doutValid_q;
        doutLast_d  = doutLast_q;

        if (slotFree) begin
            doutValid_d = 1'b0;
        end

        unique case (state_q)
            IDLE, MSG: begin
                if (accept) begin
                    par_d[0] = tapProd[0];
                    for (int i = 1; i < NPAR; i++) begin
                        par_d[i] = par_q[i-1] ^ tapProd[i];
                    end
                    dout_d      = din;
                    doutValid_d = 1'b1;
                    doutLast_d  = 1'b0;
                    msgCnt_d    = msgCntNext;
                    state_d     = (msgCntNext == msgLenCur) ? PARITY : MSG;
                end
            end
            PARITY: begin
                // Once the final parity symbol has been taken, the frame is over.
                if (slotFree) begin
                    if (parCnt_q == PAR_LEN) begin
                        state_d    = IDLE;
                        msgCnt_d   = 8'd0;
                        parCnt_d   = 8'd0;
                        doutLast_d = 1'b0;
                    end else begin
                        dout_d      = par_q[NPAR-1];
                        par_d       = {par_q[NPAR-2:0], 8'h00};
                        parCnt_d    = parCnt_q + 8'd1;
                        doutValid_d = 1'b1;
                        doutLast_d  = (parCnt_q == PAR_LEN - 8'd1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            msgCnt_q    <= 8'd0;
            parCnt_q    <= 8'd0;
            par_q       <= '0;
            dout_q      <= 8'h00;
            doutValid_q <= 1'b0;
            doutLast_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            msgCnt_q    <= msgCnt_d;
            parCnt_q    <= parCnt_d;
            par_q       <= par_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            doutLast_q  <= doutLast_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = doutValid_q;
    assign dout_last  = doutLast_q;

endmodule

// File: tb/tb_rs_encoder.sv
// tb_rs_encoder: randomized bench comparing rs_encoder (K=239 and K=1 instances)
// against a polynomial long-division RS model and syndrome evaluation.
module tb_rs_encoder;

    localparam int KMAIN = 239;
    localparam int NP    = 16;
    localparam int GUARD = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;
    logic [7:0] din1 = 8'h00;
    logic       din_valid1 = 1'b0;
    logic       din_ready1;
    logic [7:0] dout1;
    logic       dout_valid1;
    logic       dout_last1;
    logic       dout_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    int readyMode = 0;

    logic [7:0] outQ[$];
    logic [7:0] out1Q[$];
    bit         lastQ[$];
    bit         last1Q[$];

    logic [7:0] gfExp [0:509];
    int         gfLog [0:255];
    logic [7:0] genPoly [0:16];

    rs_encoder #(.K(KMAIN), .NPAR(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef RS_ENC_VARLEN_EN
        .msg_len    (8'd239),
`endif
        .dout_last  (dout_last)
    );

    rs_encoder #(.K(1), .NPAR(NP)) dutK1 (
        .clk        (clk),
        .rst        (rst),
        .din        (din1),
        .din_valid  (din_valid1),
        .din_ready  (din_ready1),
        .dout       (dout1),
        .dout_valid (dout_valid1),
        .dout_ready (dout_ready),
`ifdef RS_ENC_VARLEN_EN
        .msg_len    (8'd1),
`endif
        .dout_last  (dout_last1)
    );

    always #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = random, 2 = held off.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            1:       dout_ready = ($urandom_range(0, 3) != 0);
            2:       dout_ready = 1'b0;
            default: dout_ready = 1'b1;
        endcase
    end

    // Record every symbol that actually transfers downstream.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            outQ.push_back(dout);
            lastQ.push_back(dout_last);
        end
        if (!rst && dout_valid1 && dout_ready) begin
            out1Q.push_back(dout1);
            last1Q.push_back(dout_last1);
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gfExp[gfLog[a] + gfLog[b]];
    endfunction

    task automatic buildTables();
        logic [8:0] v;
        v = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gfExp[i]       = v[7:0];
            gfExp[i + 255] = v[7:0];
            gfLog[v[7:0]]  = i;
            v = {v[7:0], 1'b0};
            if (v[8]) v = v ^ 9'h11D;
        end
        gfLog[0] = 0;
        for (int j = 0; j <= NP; j++) genPoly[j] = 8'h00;
        genPoly[0] = 8'h01;
        for (int i = 0; i < NP; i++) begin
            for (int j = i + 1; j > 0; j--) begin
                genPoly[j] = genPoly[j-1] ^ gmul(genPoly[j], gfExp[i]);
            end
            genPoly[0] = gmul(genPoly[0], gfExp[i]);
        end
    endtask

    // Codeword = message followed by remainder of m(x)*x^16 divided by g(x).
    function automatic void modelCodeword(input logic [7:0] msg[$], output logic [7:0] cw[$]);
        logic [7:0] work[$];
        logic [7:0] c;
        int         n;
        n    = msg.size();
        work = msg;
        for (int i = 0; i < NP; i++) work.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            c = work[i];
            if (c != 8'h00) begin
                for (int j = 0; j <= NP; j++) work[i+j] = work[i+j] ^ gmul(c, genPoly[NP-j]);
            end
        end
        cw = msg;
        for (int i = 0; i < NP; i++) cw.push_back(work[n+i]);
    endfunction

    function automatic logic [7:0] syndrome(input logic [7:0] cw[$], input int j);
        logic [7:0] s;
        s = 8'h00;
        foreach (cw[i]) s = gmul(s, gfExp[j]) ^ cw[i];
        return s;
    endfunction

    task automatic driveMsg(input int which, input logic [7:0] msg[$]);
        int idx;
        int guard;
        bit acc;
        idx   = 0;
        guard = 0;
        while (idx < msg.size() && guard < GUARD) begin
            if (which == 0) begin
                din = msg[idx];
                din_valid = 1'b1;
            end else begin
                din1 = msg[idx];
                din_valid1 = 1'b1;
            end
            @(negedge clk);
            acc = (which == 0) ? din_ready : din_ready1;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        din_valid  = 1'b0;
        din_valid1 = 1'b0;
        if (idx < msg.size()) begin
            total++;
            bad++;
            $display("[TB] FAIL drive_timeout: accepted %0d required %0d", idx, msg.size());
        end
    endtask

    task automatic waitOut(input int which, input int target);
        int guard;
        guard = 0;
        while (((which == 0) ? outQ.size() : out1Q.size()) < target && guard < GUARD) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        if (((which == 0) ? outQ.size() : out1Q.size()) < target) begin
            total++;
            bad++;
            $display("[TB] FAIL output_timeout: got %0d symbols required %0d", (which == 0) ? outQ.size() : out1Q.size(), target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dout_valid: got %b required 0", dout_valid); end
        total++; if (dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout: got %h required 00", dout); end
        total++; if (dout_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_dout_last: got %b required 0", dout_last); end
        total++; if (din_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_din_ready: got %b required 1", din_ready); end
        total++; if (din_ready1 !== 1'b1) begin bad++; $display("[TB] FAIL reset_din_ready_k1: got %b required 1", din_ready1); end
        total++; if (dout_valid1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_dout_valid_k1: got %b required 0", dout_valid1); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_msg();
        logic [7:0] msg[$];
        int base;
        base = outQ.size();
        for (int i = 0; i < KMAIN; i++) msg.push_back(8'h00);
        driveMsg(0, msg);
        waitOut(0, base + KMAIN + NP);
        total++;
        if (outQ.size() != base + KMAIN + NP) begin
            bad++;
            $display("[TB] FAIL zero_count: got %0d required %0d", outQ.size() - base, KMAIN + NP);
        end else begin
            for (int i = 0; i < KMAIN + NP; i++) begin
                total++; if (outQ[base+i] !== 8'h00) begin bad++; $display("[TB] FAIL zero_sym[%0d]: got %h required 00", i, outQ[base+i]); end
                total++; if (lastQ[base+i] != (i == KMAIN + NP - 1)) begin bad++; $display("[TB] FAIL zero_last[%0d]: got %0d required %0d", i, lastQ[base+i], i == KMAIN + NP - 1); end
            end
        end
        @(negedge clk);
        total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid_clear: got %b required 0", dout_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_generator();
        logic [7:0] msg[$];
        int base;
        base = outQ.size();
        for (int i = 0; i < KMAIN - 1; i++) msg.push_back(8'h00);
        msg.push_back(8'h01);
        driveMsg(0, msg);
        waitOut(0, base + KMAIN + NP);
        for (int i = 0; i < NP; i++) begin
            total++;
            if (outQ.size() <= base + KMAIN + i || outQ[base+KMAIN+i] !== genPoly[NP-1-i]) begin
                bad++;
                $display("[TB] FAIL gen_parity[%0d]: got %h required %h", i,
                         (outQ.size() > base + KMAIN + i) ? outQ[base+KMAIN+i] : 8'hxx, genPoly[NP-1-i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] msg[$];
        logic [7:0] cw[$];
        logic [7:0] got[$];
        logic [7:0] s;
        int base;
        readyMode = 1;
        for (int f = 0; f < 2; f++) begin
            msg.delete();
            got.delete();
            base = outQ.size();
            for (int i = 0; i < KMAIN; i++) msg.push_back(8'($urandom_range(0, 255)));
            modelCodeword(msg, cw);
            driveMsg(0, msg);
            waitOut(0, base + KMAIN + NP);
            total++;
            if (outQ.size() != base + KMAIN + NP) begin
                bad++;
                $display("[TB] FAIL rand_count: got %0d required %0d", outQ.size() - base, KMAIN + NP);
            end else begin
                for (int i = 0; i < KMAIN + NP; i++) begin
                    got.push_back(outQ[base+i]);
                    total++; if (outQ[base+i] !== cw[i]) begin bad++; $display("[TB] FAIL rand_sym[%0d]: got %h required %h", i, outQ[base+i], cw[i]); end
                    total++; if (lastQ[base+i] != (i == KMAIN + NP - 1)) begin bad++; $display("[TB] FAIL rand_last[%0d]: got %0d required %0d", i, lastQ[base+i], i == KMAIN + NP - 1); end
                end
                for (int j = 0; j < NP; j++) begin
                    s = syndrome(got, j);
                    total++; if (s !== 8'h00) begin bad++; $display("[TB] FAIL rand_syndrome[%0d]: got %h required 00", j, s); end
                end
            end
        end
        readyMode = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] msg[$];
        logic [7:0] cw[$];
        int base;
        base = outQ.size();
        for (int i = 0; i < KMAIN; i++) msg.push_back(8'($urandom_range(0, 255)));
        modelCodeword(msg, cw);
        fork
            driveMsg(0, msg);
            begin : stallCtl
                int points [2];
                logic [7:0] held;
                bit heldLast;
                int g;
                points[0] = base + 100;
                points[1] = base + KMAIN + 5;
                for (int p = 0; p < 2; p++) begin
                    g = 0;
                    while (outQ.size() < points[p] && g < GUARD) begin @(negedge clk); g++; end
                    readyMode = 2;
                    g = 0;
                    @(negedge clk);
                    while (dout_ready && g < 5) begin @(negedge clk); g++; end
                    held = dout;
                    heldLast = dout_last;
                    total++; if (din_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_din_ready[%0d]: got %b required 0", p, din_ready); end
                    for (int c = 0; c < 4; c++) begin
                        @(negedge clk);
                        total++; if (dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid[%0d]: got %b required 1", p, dout_valid); end
                        total++; if (dout !== held) begin bad++; $display("[TB] FAIL stall_dout[%0d]: got %h required %h", p, dout, held); end
                        total++; if (dout_last !== heldLast) begin bad++; $display("[TB] FAIL stall_last[%0d]: got %b required %b", p, dout_last, heldLast); end
                        total++; if (din_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_din_ready[%0d]: got %b required 0", p, din_ready); end
                    end
                    readyMode = 0;
                end
            end
        join
        waitOut(0, base + KMAIN + NP);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (outQ.size() != base + KMAIN + NP) begin
            bad++;
            $display("[TB] FAIL stall_count: got %0d required %0d", outQ.size() - base, KMAIN + NP);
        end else begin
            for (int i = 0; i < KMAIN + NP; i++) begin
                total++; if (outQ[base+i] !== cw[i]) begin bad++; $display("[TB] FAIL stall_sym[%0d]: got %h required %h", i, outQ[base+i], cw[i]); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] msg[$];
        logic [7:0] cw[$];
        int base;
        int held;
        int g;
        base = outQ.size();
        for (int i = 0; i < KMAIN; i++) msg.push_back(8'($urandom_range(0, 255)));
        driveMsg(0, msg);
        g = 0;
        while (outQ.size() < base + KMAIN + 7 && g < GUARD) begin @(negedge clk); g++; end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        held = outQ.size();
        @(negedge clk);
        total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %b required 0", dout_valid); end
        total++; if (dout !== 8'h00) begin bad++; $display("[TB] FAIL midrst_dout: got %h required 00", dout); end
        total++; if (dout_last !== 1'b0) begin bad++; $display("[TB] FAIL midrst_last: got %b required 0", dout_last); end
        repeat (20) @(negedge clk);
        total++; if (outQ.size() != held) begin bad++; $display("[TB] FAIL midrst_extra: got %0d symbols required %0d", outQ.size(), held); end
        @(posedge clk);
        #1;
        msg.delete();
        msg.push_back(8'h05);
        modelCodeword(msg, cw);
        base = out1Q.size();
        driveMsg(1, msg);
        waitOut(1, base + 1 + NP);
        for (int i = 0; i < 1 + NP; i++) begin
            total++;
            if (out1Q.size() <= base + i || out1Q[base+i] !== cw[i] || last1Q[base+i] != (i == NP)) begin
                bad++;
                $display("[TB] FAIL k1_sym[%0d]: got %h required %h", i,
                         (out1Q.size() > base + i) ? out1Q[base+i] : 8'hxx, cw[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg[$];
        logic [7:0] cw[$];
        logic [7:0] one[$];
        logic [7:0] part[$];
        int base;
        base = out1Q.size();
        for (int f = 0; f < 4; f++) begin
            one.delete();
            one.push_back(8'($urandom_range(0, 255)));
            msg.push_back(one[0]);
            modelCodeword(one, part);
            foreach (part[i]) cw.push_back(part[i]);
        end
        fork
            driveMsg(1, msg);
            begin : frameGap
                int g;
                for (int f = 0; f < 4; f++) begin
                    g = 0;
                    @(negedge clk);
                    while (!(dout_valid1 && dout_ready && dout_last1) && g < 200) begin @(negedge clk); g++; end
                    if (g >= 200) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL b2b_last_timeout: frame %0d", f);
                    end else if (f < 3) begin
                        @(negedge clk);
                        total++; if (din_ready1 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready[%0d]: got %b required 1", f, din_ready1); end
                    end
                end
            end
        join
        waitOut(1, base + 4 * (1 + NP));
        total++;
        if (out1Q.size() != base + 4 * (1 + NP)) begin
            bad++;
            $display("[TB] FAIL b2b_count: got %0d required %0d", out1Q.size() - base, 4 * (1 + NP));
        end else begin
            for (int i = 0; i < 4 * (1 + NP); i++) begin
                total++; if (out1Q[base+i] !== cw[i]) begin bad++; $display("[TB] FAIL b2b_sym[%0d]: got %h required %h", i, out1Q[base+i], cw[i]); end
            end
        end
    endtask

    initial begin
        buildTables();
        test_reset();
        test_zero_msg();
        test_generator();
        test_random();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
